// File: rtl/mem_stream_reader.sv
// Reads NWORDS vector words from RAM starting at BASE and streams each word
// out as 24 bytes, LSB first, over a valid/ready byte interface.
module mem_stream_reader #(
  parameter S      = 32,
  parameter V      = 192,
  parameter BASE   = 'd31000,
  parameter NWORDS = 1250,
  parameter STRIDE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [S-1:0] address,
  output logic         VecOp,
  input  logic [V-1:0] rd,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [S-1:0] BASE_S   = S'(BASE);
  localparam logic [S-1:0] STRIDE_S = S'(STRIDE);
  localparam logic [S-1:0] LAST_IDX = S'(NWORDS - 1);
  localparam logic [4:0]   LAST_B   = 5'(V / 8 - 1);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, STREAM, DONE} state_t;

  state_t       r_state;
  logic [S-1:0] r_idx;
  logic [4:0]   r_bcnt;
  logic [V-1:0] r_sreg;
  logic         r_valid, r_busy, r_done, r_vec;

  // Address is a pure function of idx, so it reads BASE whenever idx is 0.
  assign address   = BASE_S + r_idx * STRIDE_S;
  assign out_data  = r_sreg[7:0];
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign VecOp     = r_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_sreg  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_vec   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= FETCH;
          r_idx   <= '0;
          r_bcnt  <= '0;
          r_busy  <= 1'b1;
          r_vec   <= 1'b1;
        end
        FETCH: r_state <= CAPTURE;
        CAPTURE: begin
          r_sreg  <= rd;
          r_state <= STREAM;
          r_vec   <= 1'b0;
          r_valid <= 1'b1;
        end
        STREAM: if (out_ready) begin
          r_sreg <= r_sreg >> 8;
          if (r_bcnt == LAST_B) begin
            r_valid <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_bcnt  <= '0;
              r_state <= FETCH;
              r_vec   <= 1'b1;
            end
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench: two instances (NWORDS=2 and NWORDS=1) fed by a one-cycle
// latency RAM model; expected bytes/addresses queued at start, popped on output.
module tb_mem_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start_a, start_b, rdy_a, rdy_b;
  logic [31:0]  addr_a, addr_b;
  logic [191:0] rd_a, rd_b;
  logic [7:0]   data_a, data_b;
  logic         vld_a, vld_b, vec_a, vec_b, busy_a, busy_b, done_a, done_b;

  mem_stream_reader #(.S(32), .V(192), .BASE(31000), .NWORDS(2), .STRIDE(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .address(addr_a), .VecOp(vec_a), .rd(rd_a),
    .out_data(data_a), .out_valid(vld_a), .out_ready(rdy_a), .busy(busy_a), .done(done_a));

  mem_stream_reader #(.S(32), .V(192), .BASE(31000), .NWORDS(1), .STRIDE(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .address(addr_b), .VecOp(vec_b), .rd(rd_b),
    .out_data(data_b), .out_valid(vld_b), .out_ready(rdy_b), .busy(busy_b), .done(done_b));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [191:0] mkrd(input logic [31:0] a);
    logic [191:0] r;
    logic [31:0]  k;
    k = a - 32'd31000;
    for (int j = 0; j < 24; j++) r[8*j +: 8] = 8'(k * 32 + j);
    return r;
  endfunction

  always @(posedge clk) begin
    rd_a <= mkrd(addr_a);
    rd_b <= mkrd(addr_b);
  end

  int qa[$], qb[$], aqa[$], aqb[$];
  int acc_a = 0, dcnt_a = 0, dcnt_b = 0;
  logic stall_a = 0, pvec_a = 0, pvec_b = 0;
  logic [7:0] pdata_a = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (stall_a) begin
        chk("stall_vld", 32'(vld_a), 1);
        chk("stall_data", 32'(data_a), 32'(pdata_a));
      end
      if (vld_a && rdy_a) begin
        if (qa.size() == 0) chk("a_extra_byte", 1, 0);
        else chk("a_byte", 32'(data_a), qa.pop_front());
        acc_a++;
      end
      if (vec_a && !pvec_a) begin
        if (aqa.size() == 0) chk("a_extra_fetch", 1, 0);
        else chk("a_addr", addr_a, aqa.pop_front());
      end
      if (done_a) dcnt_a++;
      stall_a = vld_a && !rdy_a;
      pdata_a = data_a;
      pvec_a  = vec_a;
    end else begin
      stall_a = 1'b0;
      pvec_a  = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (vld_b && rdy_b) begin
        if (qb.size() == 0) chk("b_extra_byte", 1, 0);
        else chk("b_byte", 32'(data_b), qb.pop_front());
      end
      if (vec_b && !pvec_b) begin
        if (aqb.size() == 0) chk("b_extra_fetch", 1, 0);
        else chk("b_addr", addr_b, aqb.pop_front());
      end
      if (done_b) dcnt_b++;
      pvec_b = vec_b;
    end else begin
      pvec_b = 1'b0;
    end
  end

  task automatic push_a();
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 24; j++) qa.push_back(k * 32 + j);
    aqa.push_back(31000);
    aqa.push_back(31001);
  endtask

  // Waits for done; n is the cycle count after start was sampled (0 on timeout).
  task automatic wait_done(input bit tog, output int n);
    n = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      if (tog) rdy_a = ~rdy_a;
      if (done_a) begin n = i; break; end
    end
    if (n == 0) chk("a_timeout", 0, 1);
    rdy_a = 1'b1;
  endtask

  task automatic go_a();
    push_a();
    start_a = 1'b1;
  endtask

  task automatic wait_acc(input int base, input int nb);
    bit hit = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      if (acc_a - base >= nb) begin hit = 1; break; end
    end
    if (!hit) chk("acc_timeout", 0, 1);
  endtask

  initial begin
    int n, d0, base, t1, t2, seen;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_addr", addr_a, 31000);
    chk("rst_vld", 32'(vld_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_vec", 32'(vec_a), 0);
    chk("rst_data", 32'(data_a), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Plain two-word transfer, ready held high
    go_a();
    wait_done(0, n);
    chk("done_cycle", n, 53);
    repeat (3) @(posedge clk); #1;
    chk("t1_qempty", 32'(qa.size()), 0);
    chk("t1_busy", 32'(busy_a), 0);

    // Ready toggling every cycle
    go_a();
    wait_done(1, n);
    repeat (3) @(posedge clk); #1;
    chk("t2_qempty", 32'(qa.size()), 0);

    // Start pulsed mid-stream is ignored
    d0 = dcnt_a;
    go_a();
    @(posedge clk); #1; start_a = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("t3_busy_mid", 32'(busy_a), 1);
    start_a = 1'b1;
    wait_done(0, n);
    repeat (60) @(posedge clk); #1;
    chk("t3_one_done", 32'(dcnt_a - d0), 1);
    chk("t3_no_queue", 32'(busy_a), 0);
    chk("t3_qempty", 32'(qa.size()), 0);

    // Reset after byte 10 of word 1
    base = acc_a;
    go_a();
    wait_acc(base, 35);
    rst = 1'b0; #1;
    chk("t4_vld", 32'(vld_a), 0);
    chk("t4_busy", 32'(busy_a), 0);
    chk("t4_done", 32'(done_a), 0);
    chk("t4_addr", addr_a, 31000);
    chk("t4_vec", 32'(vec_a), 0);
    qa.delete(); aqa.delete(); qb.delete(); aqb.delete();
    d0 = dcnt_a;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("t4_no_done", 32'(dcnt_a), 32'(d0));
    chk("t4_idle", 32'(busy_a), 0);
    go_a();
    wait_done(0, n);
    chk("t4_restart_cycle", n, 53);

    // 100-cycle stall at byte 5
    repeat (3) @(posedge clk); #1;
    base = acc_a;
    go_a();
    wait_acc(base, 5);
    rdy_a = 1'b0;
    repeat (100) @(posedge clk); #1;
    chk("t5_vld", 32'(vld_a), 1);
    chk("t5_data", 32'(data_a), 5);
    rdy_a = 1'b1;
    wait_done(0, n);
    repeat (3) @(posedge clk); #1;
    chk("t5_qempty", 32'(qa.size()), 0);

    // NWORDS=1 with start held high: two back-to-back transfers
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 24; j++) qb.push_back(j);
      aqb.push_back(31000);
    end
    start_b = 1'b1;
    t1 = 0; t2 = 0; seen = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (done_b) begin
        seen++;
        if (seen == 1) t1 = i;
        else begin t2 = i; start_b = 1'b0; break; end
      end
    end
    start_b = 1'b0;
    chk("b_first_done", t1, 27);
    chk("b_gap", t2 - t1, 28);
    repeat (40) @(posedge clk); #1;
    chk("b_dcnt", 32'(dcnt_b), 2);
    chk("b_busy", 32'(busy_b), 0);
    chk("b_qempty", 32'(qb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
